// File: rtl/div_seq_pkg.sv
// Shared ALU definitions for the iterative divider: default width, FSM
// state encoding and the quotient value reported for a zero divisor.
package div_seq_pkg;

   localparam int DIV_WIDTH = 32;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIX,
      DONE
   } div_state_e;

   // A divide by zero returns an all-ones quotient, as RISC-V M requires.
   localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOT = '1;

endpackage

// File: rtl/div_sub_step.sv
// Combinational W-bit subtract a - b, done as a + ~b + 1 on the adder.
// The carry out is set exactly when a >= b (unsigned), which is the
// "trial subtraction succeeded" flag. With a = 0 the same block acts as
// a two's-complement negator.
module div_sub_step #(
   parameter int W = 33
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   output logic [W-1:0] diff_o,
   output logic         nonNeg_o
);

   // Inverted second operand with carry-in 1; the extra top bit is the carry out.
   always_comb begin
      {nonNeg_o, diff_o} = {1'b0, a_i} + {1'b0, ~b_i} + {{W{1'b0}}, 1'b1};
   end

endmodule

// File: rtl/div_seq.sv
// Iterative restoring divider producing one quotient bit per cycle.
// Works on magnitudes, then fixes the signs of quotient and remainder in
// a single extra cycle. Results follow RISC-V DIV/DIVU/REM/REMU rules.
module div_seq
   import div_seq_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   input  logic             is_signed,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] ZERO_QUOT = {WIDTH{&DIV_ZERO_QUOT}};

   div_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] dvdMag_q, dvdMag_d;
   logic [WIDTH-1:0] dvsMag_q, dvsMag_d;
   logic [WIDTH-1:0] partRem_q, partRem_d;
   logic [WIDTH-1:0] qAcc_q, qAcc_d;
   logic             negQ_q, negQ_d;
   logic             negR_q, negR_d;
   logic [WIDTH-1:0] quot_q, quot_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic             dbz_q, dbz_d;

   // The stored partial remainder is always below the divisor, so it fits in
   // WIDTH bits; only the shifted value needs the extra bit.
   logic [WIDTH:0]   shiftRem;
   logic [WIDTH:0]   trialDiff;
   logic             trialNonNeg;
   logic [WIDTH-1:0] negAIn, negAOut, negBIn, negBOut;
   logic             negAZero, negBZero;
   logic             dvdNeg, dvsNeg;
   logic             unusedSink;

   assign shiftRem = {partRem_q, dvdMag_q[WIDTH-1]};

   div_sub_step #(.W(WIDTH + 1)) uTrial (
      .a_i      (shiftRem),
      .b_i      ({1'b0, dvsMag_q}),
      .diff_o   (trialDiff),
      .nonNeg_o (trialNonNeg)
   );

   // The two negators are shared: operands in IDLE, results in FIX.
   assign negAIn = (state_q == FIX) ? qAcc_q    : dividend;
   assign negBIn = (state_q == FIX) ? partRem_q : divisor;

   div_sub_step #(.W(WIDTH)) uNegA (
      .a_i      ({WIDTH{1'b0}}),
      .b_i      (negAIn),
      .diff_o   (negAOut),
      .nonNeg_o (negAZero)
   );

   div_sub_step #(.W(WIDTH)) uNegB (
      .a_i      ({WIDTH{1'b0}}),
      .b_i      (negBIn),
      .diff_o   (negBOut),
      .nonNeg_o (negBZero)
   );

   assign unusedSink = ^{trialDiff[WIDTH], negAZero, negBZero};

   assign dvdNeg      = is_signed & dividend[WIDTH-1];
   assign dvsNeg      = is_signed & divisor[WIDTH-1];
   assign in_ready    = (state_q == IDLE);
   assign out_valid   = (state_q == DONE);
   assign quotient    = quot_q;
   assign remainder   = rem_q;
   assign div_by_zero = dbz_q;

   // Next-state and datapath control: capture, iterate, sign-fix, hand off.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      dvdMag_d  = dvdMag_q;
      dvsMag_d  = dvsMag_q;
      partRem_d = partRem_q;
      qAcc_d    = qAcc_q;
      negQ_d    = negQ_q;
      negR_d    = negR_q;
      quot_d    = quot_q;
      rem_d     = rem_q;
      dbz_d     = dbz_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               if (divisor == '0) begin
                  quot_d  = ZERO_QUOT;
                  rem_d   = dividend;
                  dbz_d   = 1'b1;
                  state_d = DONE;
               end else begin
                  dvdMag_d  = dvdNeg ? negAOut : dividend;
                  dvsMag_d  = dvsNeg ? negBOut : divisor;
                  negQ_d    = dvdNeg ^ dvsNeg;
                  negR_d    = dvdNeg;
                  partRem_d = '0;
                  qAcc_d    = '0;
                  cnt_d     = CNT_W'(WIDTH - 1);
                  state_d   = CALC;
               end
            end
         end
         CALC: begin
            partRem_d = trialNonNeg ? trialDiff[WIDTH-1:0] : shiftRem[WIDTH-1:0];
            qAcc_d    = {qAcc_q[WIDTH-2:0], trialNonNeg};
            dvdMag_d  = {dvdMag_q[WIDTH-2:0], 1'b0};
            cnt_d     = cnt_q - 1'b1;
            if (cnt_q == '0) begin
               state_d = FIX;
            end
         end
         FIX: begin
            quot_d  = negQ_q ? negAOut : qAcc_q;
            rem_d   = negR_q ? negBOut : partRem_q;
            dbz_d   = 1'b0;
            state_d = DONE;
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers; reset drops any operation in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         dvdMag_q  <= '0;
         dvsMag_q  <= '0;
         partRem_q <= '0;
         qAcc_q    <= '0;
         negQ_q    <= 1'b0;
         negR_q    <= 1'b0;
         quot_q    <= '0;
         rem_q     <= '0;
         dbz_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         dvdMag_q  <= dvdMag_d;
         dvsMag_q  <= dvsMag_d;
         partRem_q <= partRem_d;
         qAcc_q    <= qAcc_d;
         negQ_q    <= negQ_d;
         negR_q    <= negR_d;
         quot_q    <= quot_d;
         rem_q     <= rem_d;
         dbz_q     <= dbz_d;
      end
   end

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed corner cases, randomized
// operations against an arithmetic reference, backpressure and reset.
module tb_div_seq;

   localparam int WIDTH = 32;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             is_signed;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_by_zero;

   int testsRun    = 0;
   int testsFailed = 0;

   div_seq #(.WIDTH(WIDTH)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .dividend    (dividend),
      .divisor     (divisor),
      .is_signed   (is_signed),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // Hard time limit so a stuck design can never hang the run.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   // RISC-V M division rules in plain arithmetic; 64-bit math absorbs MIN/-1.
   function automatic void refModel(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                    input logic s, output logic [WIDTH-1:0] q,
                                    output logic [WIDTH-1:0] r, output logic dz);
      longint sa;
      longint sb;
      longint sq;
      longint sr;
      if (b == '0) begin
         q  = '1;
         r  = a;
         dz = 1'b1;
      end else begin
         dz = 1'b0;
         if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            sq = sa / sb;
            sr = sa % sb;
            q  = sq[WIDTH-1:0];
            r  = sr[WIDTH-1:0];
         end else begin
            q = a / b;
            r = a % b;
         end
      end
   endfunction

   // Waits (bounded) for in_ready, presents one request, then scrambles inputs.
   task automatic startOp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s);
      int n = 0;
      while (!in_ready && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      dividend  = a;
      divisor   = b;
      is_signed = s;
      in_valid  = 1'b1;
      @(posedge clk); #1;
      in_valid  = 1'b0;
      dividend  = $urandom;
      divisor   = $urandom;
      is_signed = ~s;
   endtask

   // Counts cycles from the accept edge until out_valid; the cycle right after accept is 1.
   task automatic waitResult(output int lat, output bit timedOut);
      lat = 1;
      while (!out_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      timedOut = !out_valid;
   endtask

   // One-cycle out_ready pulse to complete the handshake.
   task automatic applyHandshake();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      dividend  = '0;
      divisor   = '0;
      is_signed = 1'b0;
      #12;
      testsRun++;
      if ({in_ready, out_valid, quotient, remainder, div_by_zero} !== {1'b1, 1'b0, 32'h0, 32'h0, 1'b0}) begin
         testsFailed++;
         $display("[TB] FAIL reset_state: got rdy=%b vld=%b q=%h r=%h dz=%b, expected rdy=1 vld=0 q=0 r=0 dz=0",
                  in_ready, out_valid, quotient, remainder, div_by_zero);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic        s;
      logic [31:0] q;
      logic [31:0] r;
      logic        dz;
   } vec_t;

   task automatic test_directed();
      vec_t vecs[7];
      int   lat;
      int   expLat;
      bit   timedOut;
      vecs = '{
         '{32'd100,       32'd7,         1'b0, 32'd14,        32'd2,         1'b0},
         '{32'hFFFF_FFF9, 32'd2,         1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0},
         '{32'd7,         32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1,         1'b0},
         '{32'h1234_5678, 32'd0,         1'b0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1},
         '{32'h1234_5678, 32'd0,         1'b1, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1},
         '{32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0,         1'b0},
         '{32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0,         32'h8000_0000, 1'b0}
      };
      foreach (vecs[i]) begin
         startOp(vecs[i].a, vecs[i].b, vecs[i].s);
         waitResult(lat, timedOut);
         expLat = (vecs[i].b == 32'd0) ? 1 : WIDTH + 2;
         testsRun++;
         if (timedOut || lat !== expLat) begin
            testsFailed++;
            $display("[TB] FAIL directed_latency[%0d]: got %0d cycles, expected %0d", i, lat, expLat);
         end
         testsRun++;
         if ({quotient, remainder, div_by_zero} !== {vecs[i].q, vecs[i].r, vecs[i].dz}) begin
            testsFailed++;
            $display("[TB] FAIL directed_result[%0d]: got q=%h r=%h dz=%b, expected q=%h r=%h dz=%b",
                     i, quotient, remainder, div_by_zero, vecs[i].q, vecs[i].r, vecs[i].dz);
         end
         applyHandshake();
      end
   endtask

   task automatic test_random();
      logic [WIDTH-1:0] a, b, eq, er;
      logic             s, edz;
      int               lat;
      bit               timedOut;
      for (int i = 0; i < 40; i++) begin
         a = $urandom;
         s = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 4))
            0: b = WIDTH'($urandom_range(1, 15));
            1: b = $urandom;
            2: b = '0;
            3: b = $urandom_range(0, 1) ? '1 : WIDTH'(1);
            default: begin
               b = $urandom;
               a = WIDTH'($urandom_range(0, 100));
            end
         endcase
         refModel(a, b, s, eq, er, edz);
         startOp(a, b, s);
         waitResult(lat, timedOut);
         testsRun++;
         if (timedOut || {quotient, remainder, div_by_zero} !== {eq, er, edz}
             || lat !== ((b == '0) ? 1 : WIDTH + 2)) begin
            testsFailed++;
            $display("[TB] FAIL random[%0d] %h/%h s=%b: got q=%h r=%h dz=%b lat=%0d, expected q=%h r=%h dz=%b",
                     i, a, b, s, quotient, remainder, div_by_zero, lat, eq, er, edz);
         end
         applyHandshake();
      end
   endtask

   task automatic test_back_to_back();
      logic [WIDTH-1:0] eq, er;
      logic             edz;
      int               lat;
      bit               timedOut;
      refModel(32'd1000, 32'd33, 1'b0, eq, er, edz);
      startOp(32'd1000, 32'd33, 1'b0);
      waitResult(lat, timedOut);
      testsRun++;
      if (timedOut) begin
         testsFailed++;
         $display("[TB] FAIL stall_start: got no out_valid, expected out_valid within budget");
      end
      // Ten stalled cycles with competing requests that must be ignored.
      for (int c = 0; c < 10; c++) begin
         in_valid  = 1'b1;
         dividend  = $urandom;
         divisor   = $urandom;
         is_signed = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
         testsRun++;
         if ({out_valid, in_ready, quotient, remainder, div_by_zero} !== {1'b1, 1'b0, eq, er, edz}) begin
            testsFailed++;
            $display("[TB] FAIL stall[%0d]: got vld=%b rdy=%b q=%h r=%h dz=%b, expected vld=1 rdy=0 q=%h r=%h dz=%b",
                     c, out_valid, in_ready, quotient, remainder, div_by_zero, eq, er, edz);
         end
      end
      in_valid = 1'b0;
      applyHandshake();
      testsRun++;
      if ({in_ready, out_valid} !== 2'b10) begin
         testsFailed++;
         $display("[TB] FAIL after_handshake: got rdy=%b vld=%b, expected rdy=1 vld=0", in_ready, out_valid);
      end
      // Accept on the very next edge after the handshake.
      refModel(32'hFFFF_FF9C, 32'd9, 1'b1, eq, er, edz);
      startOp(32'hFFFF_FF9C, 32'd9, 1'b1);
      testsRun++;
      if (in_ready !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL b2b_accept: got rdy=%b after request edge, expected rdy=0", in_ready);
      end
      waitResult(lat, timedOut);
      testsRun++;
      if (timedOut || lat !== WIDTH + 2 || {quotient, remainder} !== {eq, er}) begin
         testsFailed++;
         $display("[TB] FAIL b2b_result: got q=%h r=%h lat=%0d, expected q=%h r=%h lat=%0d",
                  quotient, remainder, lat, eq, er, WIDTH + 2);
      end
      applyHandshake();
   endtask

   task automatic test_reset_mid_calc();
      int  lat;
      bit  timedOut;
      bit  sawValid = 1'b0;
      startOp(32'hFFFF_0000, 32'd3, 1'b0);
      repeat (14) begin
         @(posedge clk); #1;
      end
      #2;
      rst = 1'b1;
      #1;
      testsRun++;
      if ({in_ready, out_valid, quotient, remainder, div_by_zero} !== {1'b1, 1'b0, 32'h0, 32'h0, 1'b0}) begin
         testsFailed++;
         $display("[TB] FAIL mid_calc_reset: got rdy=%b vld=%b q=%h r=%h dz=%b, expected rdy=1 vld=0 q=0 r=0 dz=0",
                  in_ready, out_valid, quotient, remainder, div_by_zero);
      end
      rst = 1'b0;
      for (int c = 0; c < 50; c++) begin
         @(posedge clk); #1;
         if (out_valid) sawValid = 1'b1;
      end
      testsRun++;
      if (sawValid) begin
         testsFailed++;
         $display("[TB] FAIL no_result_after_reset: got out_valid=1, expected out_valid=0");
      end
      startOp(32'd8, 32'd3, 1'b0);
      waitResult(lat, timedOut);
      testsRun++;
      if (timedOut || {quotient, remainder, div_by_zero} !== {32'd2, 32'd2, 1'b0}) begin
         testsFailed++;
         $display("[TB] FAIL post_reset_op: got q=%h r=%h dz=%b, expected q=2 r=2 dz=0",
                  quotient, remainder, div_by_zero);
      end
      applyHandshake();
   endtask

   // Scenario sequence and summary.
   initial begin
      test_reset();
      test_directed();
      test_random();
      test_back_to_back();
      test_reset_mid_calc();
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
